out_channel_checker: RTL and testbench

//  Downstream consumer of the program-interpreter out channel: accepts each emitted word over valid/ready,

---
 rtl/fpga_pkg.sv | 14 +
 rtl/out_capture_ring.sv | 54 +++++
 rtl/out_channel_checker.sv | 165 ++++++++++++++++
 tb/tb_out_channel_checker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pkg.sv
// Types shared by the program-interpreter top and its out-channel checker.
package fpga_pkg;

    localparam int MemoryElementWidth = 12;

    typedef logic [MemoryElementWidth-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD,
        CHECK,
        DONE
    } chk_state_t;

endpackage

// File: rtl/out_capture_ring.sv
// Ring buffer recording every accepted out-channel word; holds the most recent NExpected words.
// Only compiled when OUT_CHANNEL_CAPTURE_EN is defined.
`ifdef OUT_CHANNEL_CAPTURE_EN
module out_capture_ring #(
    parameter int MemoryElementWidth = 12,
    parameter int NExpected          = 4,
    parameter int IdxW               = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [MemoryElementWidth-1:0] wr_data,
    input  logic [IdxW-1:0]               rd_addr,
    output logic [MemoryElementWidth-1:0] rd_data
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NExpected - 1);

    logic [IdxW-1:0]               wr_ptr;
    logic [MemoryElementWidth-1:0] ring [NExpected];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == LastIdx) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset; only the pointer is.
    always_ff @(posedge clock) begin
        if (wr_en && !clear) begin
            for (int i = 0; i < NExpected; i++) begin
                if (wr_ptr == IdxW'(i)) begin
                    ring[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NExpected; i++) begin
            if (rd_addr == IdxW'(i)) begin
                rd_data = ring[i];
            end
        end
    end

endmodule
`endif

// File: rtl/out_channel_checker.sv
// Consumes the interpreter out channel, compares words in order against a loaded table and
// reports finished/success. Optional capture ring enabled by OUT_CHANNEL_CAPTURE_EN.
module out_channel_checker
    import fpga_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NExpected          = 4,
    parameter int IdxW               = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_we,
    input  logic [IdxW-1:0]               exp_addr,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [MemoryElementWidth-1:0] in_data,
    output logic                          in_ready,
    input  logic                          prog_done,
    output logic [IdxW-1:0]               count,
    output logic                          mismatch,
    output logic [IdxW-1:0]               mismatch_idx,
    output logic                          finished,
    output logic                          success,
    input  logic [IdxW-1:0]               cap_addr,
    output logic [MemoryElementWidth-1:0] cap_data
);

    localparam logic [IdxW-1:0] NExp     = IdxW'(NExpected);
    localparam logic [IdxW-1:0] CountMax = '1;

    chk_state_t state, state_nxt;

    logic [MemoryElementWidth-1:0] exp_table [NExpected];
    logic [MemoryElementWidth-1:0] exp_word;

    logic            xfer;
    logic            word_bad;
    logic [IdxW-1:0] count_post, idx_post;
    logic            mm_post;
    logic [IdxW-1:0] count_nxt, idx_nxt;
    logic            mm_nxt, fin_nxt, succ_nxt;

    assign in_ready = (state == CHECK);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (state == LOAD && exp_we) begin
            for (int i = 0; i < NExpected; i++) begin
                if (exp_addr == IdxW'(i)) begin
                    exp_table[i] <= exp_data;
                end
            end
        end
    end

    always_comb begin
        exp_word = '0;
        for (int i = 0; i < NExpected; i++) begin
            if (count == IdxW'(i)) begin
                exp_word = exp_table[i];
            end
        end
    end

    // Post-transfer view of the counters, so a word arriving with prog_done is judged first.
    always_comb begin
        word_bad   = (count >= NExp) || (in_data != exp_word);
        count_post = count;
        mm_post    = mismatch;
        idx_post   = mismatch_idx;
        if (xfer) begin
            if (count != CountMax) begin
                count_post = count + 1'b1;
            end
            if (word_bad && !mismatch) begin
                mm_post  = 1'b1;
                idx_post = count;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mm_nxt    = mismatch;
        idx_nxt   = mismatch_idx;
        fin_nxt   = finished;
        succ_nxt  = success;
        unique case (state)
            LOAD, DONE: begin
                if (start) begin
                    state_nxt = CHECK;
                    count_nxt = '0;
                    mm_nxt    = 1'b0;
                    idx_nxt   = '0;
                    fin_nxt   = 1'b0;
                    succ_nxt  = 1'b0;
                end
            end
            CHECK: begin
                if (start) begin
                    count_nxt = '0;
                    mm_nxt    = 1'b0;
                    idx_nxt   = '0;
                    fin_nxt   = 1'b0;
                    succ_nxt  = 1'b0;
                end else begin
                    count_nxt = count_post;
                    mm_nxt    = mm_post;
                    idx_nxt   = idx_post;
                    if (prog_done) begin
                        state_nxt = DONE;
                        fin_nxt   = 1'b1;
                        succ_nxt  = !mm_post && (count_post == NExp);
                        if (count_post < NExp && !mm_post) begin
                            mm_nxt  = 1'b1;
                            idx_nxt = count_post;
                        end
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            count        <= '0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
            finished     <= 1'b0;
            success      <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            mismatch     <= mm_nxt;
            mismatch_idx <= idx_nxt;
            finished     <= fin_nxt;
            success      <= succ_nxt;
        end
    end

`ifdef OUT_CHANNEL_CAPTURE_EN
    out_capture_ring #(
        .MemoryElementWidth(MemoryElementWidth),
        .NExpected         (NExpected),
        .IdxW              (IdxW)
    ) u_ring (
        .clock  (clock),
        .reset  (reset),
        .clear  (start),
        .wr_en  (xfer && !start),
        .wr_data(in_data),
        .rd_addr(cap_addr),
        .rd_data(cap_data)
    );
`else
    logic unused_cap;
    assign unused_cap = ^cap_addr;
    assign cap_data   = '0;
`endif

endmodule

// File: tb/tb_out_channel_checker.sv
// Scoreboard bench for out_channel_checker: stimulus queues expected verdicts, a monitor checks them.
module tb_out_channel_checker;

    localparam int MEW  = 12;
    localparam int NEXP = 4;
    localparam int IDXW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            exp_we = 1'b0;
    logic [IDXW-1:0] exp_addr = '0;
    logic [MEW-1:0]  exp_data = '0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic [MEW-1:0]  in_data = '0;
    logic            in_ready;
    logic            prog_done = 1'b0;
    logic [IDXW-1:0] count;
    logic            mismatch;
    logic [IDXW-1:0] mismatch_idx;
    logic            finished;
    logic            success;
    logic [IDXW-1:0] cap_addr = '0;
    logic [MEW-1:0]  cap_data;

    typedef struct {
        string           name;
        logic [IDXW-1:0] count;
        logic            mismatch;
        logic [IDXW-1:0] idx;
        logic            success;
        int              cyc;
    } verdict_t;

    verdict_t exp_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;
    int       cyc      = 0;
    logic     prev_fin = 1'b0;

    out_channel_checker #(
        .MemoryElementWidth(MEW),
        .NExpected         (NEXP),
        .IdxW              (IDXW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .exp_we      (exp_we),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .prog_done   (prog_done),
        .count       (count),
        .mismatch    (mismatch),
        .mismatch_idx(mismatch_idx),
        .finished    (finished),
        .success     (success),
        .cap_addr    (cap_addr),
        .cap_data    (cap_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: a rising finished is the DUT presenting a verdict.
    always @(negedge clock) begin
        if (finished && !prev_fin) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_verdict", 32'd1, 32'd0);
            end else begin
                verdict_t v;
                v = exp_q.pop_front();
                check_val({v.name, ".count"},    32'(count),        32'(v.count));
                check_val({v.name, ".mismatch"}, 32'(mismatch),     32'(v.mismatch));
                check_val({v.name, ".idx"},      32'(mismatch_idx), 32'(v.idx));
                check_val({v.name, ".success"},  32'(success),      32'(v.success));
                check_val({v.name, ".latency"},  32'(cyc),          32'(v.cyc));
            end
        end
        prev_fin = finished;
    end

    task automatic check_output(input string name);
        check_val({name, ".in_ready"},     32'(in_ready),     32'd0);
        check_val({name, ".count"},        32'(count),        32'd0);
        check_val({name, ".mismatch"},     32'(mismatch),     32'd0);
        check_val({name, ".idx"},          32'(mismatch_idx), 32'd0);
        check_val({name, ".finished"},     32'(finished),     32'd0);
        check_val({name, ".success"},      32'(success),      32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input string name, input logic [MEW-1:0] w [8], input int n,
                                  input bit merge_done, input logic [IDXW-1:0] e_count,
                                  input bit e_mm, input logic [IDXW-1:0] e_idx, input bit e_succ);
        verdict_t v;
        v.name = name; v.count = e_count; v.mismatch = e_mm; v.idx = e_idx; v.success = e_succ;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            if (merge_done && i == n - 1) begin
                prog_done = 1'b1;
                v.cyc = cyc + 1;
                exp_q.push_back(v);
            end
            tick();
        end
        in_valid = 1'b0;
        if (!merge_done) begin
            prog_done = 1'b1;
            v.cyc = cyc + 1;
            exp_q.push_back(v);
            tick();
        end
        prog_done = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        if (exp_q.size() != 0) begin
            check_val({name, ".verdict_timeout"}, 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    logic [MEW-1:0] tbl [4] = '{12'd0, 12'd1, 12'd99, 12'd2};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_output("por");
        reset = 1'b1;
        tick();

        for (int i = 0; i < NEXP; i++) begin
            exp_we   = 1'b1;
            exp_addr = IDXW'(i);
            exp_data = tbl[i];
            tick();
        end
        exp_addr = IDXW'(NEXP);
        exp_data = 12'd5;
        tick();
        exp_we = 1'b0;

        apply_stimulus("case1", '{12'd0, 12'd1, 12'd99, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0}, 4, 1'b0,
                       8'd4, 1'b0, 8'd0, 1'b1);

        // Write attempted outside LOAD must leave the table intact.
        exp_we = 1'b1; exp_addr = 8'd0; exp_data = 12'd77;
        tick();
        exp_we = 1'b0;

        apply_stimulus("case2", '{12'd0, 12'd1, 12'd2, 12'd99, 12'd0, 12'd0, 12'd0, 12'd0}, 4, 1'b0,
                       8'd4, 1'b1, 8'd2, 1'b0);
        apply_stimulus("case3", '{12'd0, 12'd1, 12'd99, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0}, 3, 1'b0,
                       8'd3, 1'b1, 8'd3, 1'b0);
        apply_stimulus("case4", '{12'd0, 12'd1, 12'd99, 12'd2, 12'd7, 12'd0, 12'd0, 12'd0}, 5, 1'b0,
                       8'd5, 1'b1, 8'd4, 1'b0);
        apply_stimulus("case5", '{12'd0, 12'd1, 12'd99, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0}, 4, 1'b1,
                       8'd4, 1'b0, 8'd0, 1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i];
            tick();
        end
        in_valid = 1'b0;
        check_val("case6.count_before_reset", 32'(count), 32'd2);
        reset = 1'b0;
        #2;
        check_output("case6_mid_reset");
        tick();
        reset = 1'b1;
        tick();

        apply_stimulus("case6_restart", '{12'd0, 12'd1, 12'd99, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0}, 4,
                       1'b0, 8'd4, 1'b0, 8'd0, 1'b1);

        cap_addr = 8'd2;
        #1;
`ifdef OUT_CHANNEL_CAPTURE_EN
        check_val("cap_data_addr2", 32'(cap_data), 32'd99);
`else
        check_val("cap_data_tied", 32'(cap_data), 32'd0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
